// File: rtl/alu_vector_checker.sv
// ALU self-check engine: loads {func, in1, in2, expected} vectors from a word stream,
// drives the ALU, waits SETTLE cycles, then scores the result. Option: ALUCHK_ZERO_CHECK_EN.
module alu_vector_checker #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Start,
  input  logic [WIDTH-1:0]  WordIn,
  input  logic              WordValid,
  input  logic              WordLast,
  output logic              WordReady,
  output logic [FUNC_W-1:0] AluFunc,
  output logic [WIDTH-1:0]  AluIn1,
  output logic [WIDTH-1:0]  AluIn2,
  input  logic [WIDTH-1:0]  AluOut,
  input  logic              AluZero,
  output logic              Busy,
  output logic              Done,
  output logic              Mismatch,
  output logic [CNT_W-1:0]  PassCount,
  output logic [CNT_W-1:0]  FailCount,
  output logic              FirstFailValid,
  output logic [CNT_W-1:0]  FirstFailIdx,
  output logic [WIDTH-1:0]  FirstFailGot
);

  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_F, S_LD_A, S_LD_B, S_LD_Y, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SCNT_W-1:0]  settle_q, settle_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [WIDTH-1:0]   in1_q, in1_d, in2_q, in2_d, exp_q, exp_d, ffgot_q, ffgot_d;
  logic               last_q, last_d, mism_q, mism_d, ffv_q, ffv_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d, idx_q, idx_d, ffidx_q, ffidx_d;
  logic               word_ready, xfer, vec_fail;

  // Start wins over any transfer offered in the same cycle.
  assign xfer = WordValid & word_ready & ~Start;

`ifdef ALUCHK_ZERO_CHECK_EN
  assign vec_fail = (AluOut != exp_q) || (AluZero != (AluOut == '0));
`else
  logic unused_zero;
  assign unused_zero = AluZero;
  assign vec_fail    = (AluOut != exp_q);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (Start) begin
      state_d = S_LD_F;
    end else begin
      case (state_q)
        S_LD_F: if (xfer) state_d = S_LD_A;
        S_LD_A: if (xfer) state_d = S_LD_B;
        S_LD_B: if (xfer) state_d = S_LD_Y;
        S_LD_Y: if (xfer) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
        S_SETTLE: begin
          if (settle_q == SCNT_W'(SETTLE - 1)) state_d = S_CHECK;
          else settle_d = settle_q + SCNT_W'(1);
        end
        S_CHECK: state_d = last_q ? S_DONE : S_LD_F;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    word_ready = (state_q == S_LD_F) || (state_q == S_LD_A) ||
                 (state_q == S_LD_B) || (state_q == S_LD_Y);
    Busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    Done       = (state_q == S_DONE);
  end

  always_comb begin
    func_d  = func_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    exp_d   = exp_q;
    last_d  = last_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    idx_d   = idx_q;
    ffv_d   = ffv_q;
    ffidx_d = ffidx_q;
    ffgot_d = ffgot_q;
    mism_d  = 1'b0;
    if (Start) begin
      pass_d  = '0;
      fail_d  = '0;
      idx_d   = '0;
      ffv_d   = 1'b0;
      ffidx_d = '0;
      ffgot_d = '0;
    end else begin
      if (xfer) begin
        case (state_q)
          S_LD_F:  func_d = WordIn[FUNC_W-1:0];
          S_LD_A:  in1_d  = WordIn;
          S_LD_B:  in2_d  = WordIn;
          S_LD_Y: begin
            exp_d  = WordIn;
            last_d = WordLast;
          end
          default: ;
        endcase
      end
      if (state_q == S_CHECK) begin
        // Counters stick at all-ones; the vector index is allowed to wrap.
        if (vec_fail) begin
          mism_d = 1'b1;
          if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffidx_d = idx_q;
            ffgot_d = AluOut;
          end
        end else if (pass_q != '1) begin
          pass_d = pass_q + CNT_W'(1);
        end
        idx_d = idx_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      func_q  <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      exp_q   <= '0;
      last_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      ffv_q   <= 1'b0;
      ffidx_q <= '0;
      ffgot_q <= '0;
      mism_q  <= 1'b0;
    end else begin
      func_q  <= func_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      exp_q   <= exp_d;
      last_q  <= last_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      idx_q   <= idx_d;
      ffv_q   <= ffv_d;
      ffidx_q <= ffidx_d;
      ffgot_q <= ffgot_d;
      mism_q  <= mism_d;
    end
  end

  assign WordReady      = word_ready;
  assign AluFunc        = func_q;
  assign AluIn1         = in1_q;
  assign AluIn2         = in2_q;
  assign Mismatch       = mism_q;
  assign PassCount      = pass_q;
  assign FailCount      = fail_q;
  assign FirstFailValid = ffv_q;
  assign FirstFailIdx   = ffidx_q;
  assign FirstFailGot   = ffgot_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: stub ALU, vector-level timeline model checked every
// cycle, plus literal expectations per scenario.
module tb_alu_vector_checker;
  localparam int WIDTH  = 32;
  localparam int FUNC_W = 4;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n, Start, WordValid, WordLast, WordReady;
  logic [WIDTH-1:0]  WordIn, AluIn1, AluIn2, AluOut, FirstFailGot;
  logic [FUNC_W-1:0] AluFunc;
  logic              AluZero, Busy, Done, Mismatch, FirstFailValid;
  logic [CNT_W-1:0]  PassCount, FailCount, FirstFailIdx;
  logic              zero_bad = 1'b0;

  int total = 0;
  int bad   = 0;
  int mm_cnt = 0;

  alu_vector_checker #(.WIDTH(WIDTH), .FUNC_W(FUNC_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .WordIn(WordIn), .WordValid(WordValid),
    .WordLast(WordLast), .WordReady(WordReady), .AluFunc(AluFunc), .AluIn1(AluIn1),
    .AluIn2(AluIn2), .AluOut(AluOut), .AluZero(AluZero), .Busy(Busy), .Done(Done),
    .Mismatch(Mismatch), .PassCount(PassCount), .FailCount(FailCount),
    .FirstFailValid(FirstFailValid), .FirstFailIdx(FirstFailIdx), .FirstFailGot(FirstFailGot)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Stub ALU; zero_bad lets the bench corrupt the zero flag on purpose.
  always_comb begin
    AluOut  = alu_ref(AluFunc, AluIn1, AluIn2);
    AluZero = (AluOut == 32'd0) ^ zero_bad;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Vector-level model: each completed vector becomes a scored event due SETTLE+1 edges later.
  typedef struct { int due; bit fail; logic [31:0] got; bit last; } pend_t;
  pend_t pend[$];
  int          cyc = 0;
  int          m_wpos;
  logic [15:0] m_pass, m_fail, m_idx, m_ffidx;
  logic [31:0] m_ffgot, m_in1, m_in2;
  logic [3:0]  m_func;
  bit          m_ffv, m_mm, m_busy, m_done;
  bit          l_start = 0, l_xfer = 0, l_last = 0;
  logic [31:0] l_word = 0;

  always @(negedge clk) begin
    cyc++;
    m_mm = 0;
    if (!reset_n) begin
      m_wpos = 0; m_pass = 0; m_fail = 0; m_idx = 0; m_ffidx = 0; m_ffgot = 0;
      m_in1 = 0; m_in2 = 0; m_func = 0; m_ffv = 0; m_busy = 0; m_done = 0;
      pend.delete();
      l_start = 0; l_xfer = 0;
    end else if (l_start) begin
      m_wpos = 0; m_pass = 0; m_fail = 0; m_idx = 0; m_ffidx = 0; m_ffgot = 0;
      m_ffv = 0; m_busy = 1; m_done = 0;
      pend.delete();
    end else begin
      if (l_xfer) begin
        case (m_wpos)
          0: m_func = l_word[3:0];
          1: m_in1 = l_word;
          2: m_in2 = l_word;
          default: begin
            pend_t p;
            p.got  = alu_ref(m_func, m_in1, m_in2);
            p.fail = (p.got != l_word);
`ifdef ALUCHK_ZERO_CHECK_EN
            p.fail = p.fail || zero_bad;
`endif
            p.last = l_last;
            p.due  = cyc + SETTLE + 1;
            pend.push_back(p);
          end
        endcase
        m_wpos = (m_wpos + 1) % 4;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].fail) begin
          m_mm = 1;
          if (m_fail != 16'hFFFF) m_fail++;
          if (!m_ffv) begin m_ffv = 1; m_ffidx = m_idx; m_ffgot = pend[0].got; end
        end else if (m_pass != 16'hFFFF) m_pass++;
        m_idx++;
        if (pend[0].last) begin m_busy = 0; m_done = 1; end
        void'(pend.pop_front());
      end
    end
    if (Mismatch) mm_cnt++;
    chk("ready",    WordReady, m_busy && pend.size() == 0);
    chk("busy",     Busy, m_busy);
    chk("done",     Done, m_done);
    chk("mismatch", Mismatch, m_mm);
    chk("pass",     PassCount, m_pass);
    chk("fail",     FailCount, m_fail);
    chk("ffvalid",  FirstFailValid, m_ffv);
    chk("ffidx",    FirstFailIdx, m_ffidx);
    chk("ffgot",    FirstFailGot, m_ffgot);
    chk("alufunc",  AluFunc, m_func);
    chk("aluin1",   AluIn1, m_in1);
    chk("aluin2",   AluIn2, m_in2);
    if (reset_n) begin
      l_start = Start;
      l_xfer  = WordValid && WordReady && !Start;
      l_word  = WordIn;
      l_last  = WordLast;
    end
  end

  task automatic send_word(input logic [31:0] w, input bit last);
    WordIn = w; WordValid = 1; WordLast = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (WordReady) begin
        @(posedge clk); #1;
        WordValid = 0; WordLast = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("word_timeout", 0, 1);
    WordValid = 0; WordLast = 0;
  endtask

  task automatic send_vec(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] y, input bit last, input bit gap);
    logic [31:0] words[4];
    words[0] = {28'd0, f}; words[1] = a; words[2] = b; words[3] = y;
    for (int i = 0; i < 4; i++) begin
      send_word(words[i], (i == 3) && last);
      if (gap) begin @(posedge clk); #1; end
    end
    $display("vector func=%0d in1=%0h in2=%0h exp=%0h last=%0d gap=%0d", f, a, b, y, last, gap);
  endtask

  task automatic start_pulse();
    Start = 1; @(posedge clk); #1; Start = 0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (Done) begin @(posedge clk); #1; return; end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run_pair(input bit gap);
    mm_cnt = 0;
    start_pulse();
    send_vec(0, 1, 2, 3, 0, gap);
    send_vec(0, 2, 2, 5, 0, gap);
    send_vec(0, 3, 4, 7, 1, gap);
    wait_done();
    chk("t23_pass", PassCount, 2);
    chk("t23_fail", FailCount, 1);
    chk("t23_ffidx", FirstFailIdx, 1);
    chk("t23_ffgot", FirstFailGot, 4);
    chk("t23_mmcnt", mm_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; Start = 0; WordIn = 0; WordValid = 0; WordLast = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    chk("rst_busy", Busy, 0);
    chk("rst_ready", WordReady, 0);
    chk("rst_pass", PassCount, 0);

    // 1: three matching vectors
    start_pulse();
    send_vec(0, 1, 2, 3, 0, 0);
    send_vec(0, 1, 2, 3, 0, 0);
    send_vec(0, 1, 2, 3, 1, 0);
    wait_done();
    chk("t1_pass", PassCount, 3);
    chk("t1_fail", FailCount, 0);
    chk("t1_done", Done, 1);
    chk("t1_ffv", FirstFailValid, 0);

    // 2: one failing vector; 3: same with a gappy stream
    run_pair(0);
    run_pair(1);

    // 4: restart after two words of vector 2, with a word offered alongside Start
    start_pulse();
    send_vec(1, 9, 4, 5, 0, 0);
    send_vec(2, 32'hF0, 32'h3C, 32'h30, 0, 0);
    send_word(32'd3, 0);
    send_word(32'd7, 0);
    WordIn = 32'hDEAD; WordValid = 1;
    start_pulse();
    WordValid = 0;
    chk("t4_pass_clr", PassCount, 0);
    chk("t4_busy", Busy, 1);
    send_vec(3, 5, 10, 15, 0, 0);
    send_vec(0, 1, 1, 3, 0, 0);
    send_vec(4, 32'hFF, 32'h0F, 32'hF0, 1, 0);
    wait_done();
    chk("t4_pass", PassCount, 2);
    chk("t4_fail", FailCount, 1);
    chk("t4_ffidx", FirstFailIdx, 1);
    chk("t4_ffgot", FirstFailGot, 2);

    // 5: zero flag disagrees with a zero result
    zero_bad = 1;
    start_pulse();
    send_vec(0, 0, 0, 0, 1, 0);
    wait_done();
    zero_bad = 0;
`ifdef ALUCHK_ZERO_CHECK_EN
    chk("t5_fail", FailCount, 1);
    chk("t5_pass", PassCount, 0);
`else
    chk("t5_fail", FailCount, 0);
    chk("t5_pass", PassCount, 1);
`endif

    // 6: asynchronous reset while settling
    start_pulse();
    send_vec(0, 6, 7, 13, 0, 0);
    chk("t6_busy_pre", Busy, 1);
    reset_n = 0;
    #1;
    chk("t6_busy", Busy, 0);
    chk("t6_ready", WordReady, 0);
    chk("t6_in1", AluIn1, 0);
    chk("t6_func", AluFunc, 0);
    chk("t6_pass", PassCount, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_idle_busy", Busy, 0);
    chk("t6_idle_done", Done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
